demux1bit_to2_reg: RTL and testbench

Registered 1-to-2 demultiplexer with valid/ready handshake: the steering counterpart of the 2-to-1 select mux in the datapath. One input stream is routed each cycle to destination A or destination B by a select bit, using the same select convention as the mux (sel = 1 → A, sel = 0 → B). Each destination has a one-entry output register. The block also keeps per-destination transfer counters. It sits between the operand fetch stage and the two matrix-operand consumers, so one producer can feed either consumer without stalling the other.

---
 rtl/demux1bit_to2_reg.sv | 102 ++++++++++
 tb/tb_demux1bit_to2_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1bit_to2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshake and per-destination transfer counters.
// Sel = 1 steers the input to destination A, Sel = 0 to destination B.
module demux1bit_to2_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InData,
    input  logic             InValid,
    input  logic             Sel,
    output logic             InReady,
    output logic [WIDTH-1:0] OutAData,
    output logic             OutAValid,
    input  logic             OutAReady,
    output logic [WIDTH-1:0] OutBData,
    output logic             OutBValid,
    input  logic             OutBReady,
    input  logic             CntClr,
    output logic [CNT_W-1:0] CntA,
    output logic [CNT_W-1:0] CntB
);

    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    logic can_a, can_b;
    logic load_a, load_b;
    logic cons_a, cons_b;

    // A slot can take a new payload if it is empty or is being drained this cycle.
    assign can_a   = !a_valid_q || OutAReady;
    assign can_b   = !b_valid_q || OutBReady;
    assign InReady = Sel ? can_a : can_b;

    assign load_a = InValid && InReady && Sel;
    assign load_b = InValid && InReady && !Sel;
    assign cons_a = a_valid_q && OutAReady;
    assign cons_b = b_valid_q && OutBReady;

    always_comb begin
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        a_data_d  = a_data_q;
        b_data_d  = b_data_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;

        // A load wins over a same-cycle consume so the slot stays full.
        if (load_a) begin
            a_valid_d = 1'b1;
            a_data_d  = InData;
        end else if (cons_a) begin
            a_valid_d = 1'b0;
        end

        if (load_b) begin
            b_valid_d = 1'b1;
            b_data_d  = InData;
        end else if (cons_b) begin
            b_valid_d = 1'b0;
        end

        if (CntClr) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (cons_a) cnt_a_d = cnt_a_q + 1'b1;
            if (cons_b) cnt_b_d = cnt_b_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
        end
    end

    assign OutAValid = a_valid_q;
    assign OutBValid = b_valid_q;
    assign OutAData  = a_data_q;
    assign OutBData  = b_data_q;
    assign CntA      = cnt_a_q;
    assign CntB      = cnt_b_q;

endmodule

// File: tb/tb_demux1bit_to2_reg.sv
// Bench for demux1bit_to2_reg: directed vector table, hand-written corner sequences
// and a randomized run checked against a per-destination scoreboard.
module tb_demux1bit_to2_reg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic [WIDTH-1:0] InData;
    logic             InValid;
    logic             Sel;
    logic             InReady;
    logic [WIDTH-1:0] OutAData;
    logic             OutAValid;
    logic             OutAReady;
    logic [WIDTH-1:0] OutBData;
    logic             OutBValid;
    logic             OutBReady;
    logic             CntClr;
    logic [CNT_W-1:0] CntA;
    logic [CNT_W-1:0] CntB;

    demux1bit_to2_reg #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InData   (InData),
        .InValid  (InValid),
        .Sel      (Sel),
        .InReady  (InReady),
        .OutAData (OutAData),
        .OutAValid(OutAValid),
        .OutAReady(OutAReady),
        .OutBData (OutBData),
        .OutBValid(OutBValid),
        .OutBReady(OutBReady),
        .CntClr   (CntClr),
        .CntA     (CntA),
        .CntB     (CntB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        sel;
        logic        valid;
        logic [31:0] data;
        logic        ardy;
        logic        brdy;
        logic        clr;
        logic        exp_rdy;
        logic        exp_av;
        logic [31:0] exp_ad;
        logic        exp_bv;
        logic [31:0] exp_bd;
        logic [3:0]  exp_ca;
        logic [3:0]  exp_cb;
    } vec_t;

    function automatic vec_t mk(input logic sel, input logic valid, input logic [31:0] data,
                                input logic ardy, input logic brdy, input logic clr,
                                input logic rdy, input logic av, input logic [31:0] ad,
                                input logic bv, input logic [31:0] bd,
                                input logic [3:0] ca, input logic [3:0] cb);
        vec_t v;
        v.sel = sel; v.valid = valid; v.data = data; v.ardy = ardy; v.brdy = brdy;
        v.clr = clr; v.exp_rdy = rdy; v.exp_av = av; v.exp_ad = ad; v.exp_bv = bv;
        v.exp_bd = bd; v.exp_ca = ca; v.exp_cb = cb;
        return v;
    endfunction

    task automatic drive(input logic sel, input logic valid, input logic [31:0] data,
                         input logic ardy, input logic brdy, input logic clr);
        Sel = sel; InValid = valid; InData = data;
        OutAReady = ardy; OutBReady = brdy; CntClr = clr;
    endtask

    vec_t vecs[14];

    // Random-phase model state
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        m_av, m_bv, m_rdy, ld_a, ld_b, cs_a, cs_b;
    int          n_cons_a, n_cons_b, hs;

    initial begin
        //            sel val data   ar br cl | rdy av ad    bv bd    ca cb
        vecs[0]  = mk(1, 1, 32'h1,  1, 0, 0,   1,  1, 32'h1,  0, 32'h0,  0, 0);
        vecs[1]  = mk(1, 1, 32'h2,  1, 0, 0,   1,  1, 32'h2,  0, 32'h0,  1, 0);
        vecs[2]  = mk(1, 1, 32'h3,  1, 0, 0,   1,  1, 32'h3,  0, 32'h0,  2, 0);
        vecs[3]  = mk(1, 1, 32'h4,  1, 0, 0,   1,  1, 32'h4,  0, 32'h0,  3, 0);
        vecs[4]  = mk(1, 0, 32'h0,  1, 0, 0,   1,  0, 32'h4,  0, 32'h0,  4, 0);
        vecs[5]  = mk(1, 1, 32'hAA, 0, 0, 0,   1,  1, 32'hAA, 0, 32'h0,  4, 0);
        vecs[6]  = mk(1, 1, 32'h55, 0, 0, 0,   0,  1, 32'hAA, 0, 32'h0,  4, 0);
        vecs[7]  = mk(0, 1, 32'h77, 0, 0, 0,   1,  1, 32'hAA, 1, 32'h77, 4, 0);
        vecs[8]  = mk(0, 0, 32'h0,  0, 1, 0,   1,  1, 32'hAA, 0, 32'h77, 4, 1);
        vecs[9]  = mk(1, 0, 32'h0,  1, 0, 0,   1,  0, 32'hAA, 0, 32'h77, 5, 1);
        vecs[10] = mk(1, 1, 32'h5,  0, 0, 0,   1,  1, 32'h5,  0, 32'h77, 5, 1);
        vecs[11] = mk(1, 1, 32'h6,  1, 0, 0,   1,  1, 32'h6,  0, 32'h77, 6, 1);
        vecs[12] = mk(1, 0, 32'h0,  1, 0, 0,   1,  0, 32'h6,  0, 32'h77, 7, 1);
        vecs[13] = mk(0, 0, 32'hDEAD, 0, 0, 0, 1,  0, 32'h6,  0, 32'h77, 7, 1);

        Reset = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        check("reset_av", 32'(OutAValid), 32'h0);
        check("reset_bv", 32'(OutBValid), 32'h0);
        check("reset_ad", OutAData, 32'h0);
        check("reset_bd", OutBData, 32'h0);
        check("reset_ca", 32'(CntA), 32'h0);
        check("reset_cb", 32'(CntB), 32'h0);
        Reset = 1'b1;
        #1 check("reset_rdy_sel0", 32'(InReady), 32'h1);
        Sel = 1'b1;
        #1 check("reset_rdy_sel1", 32'(InReady), 32'h1);

        // Directed table: streaming, backpressure isolation, load+consume, idle don't-cares
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            drive(vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].ardy, vecs[i].brdy,
                  vecs[i].clr);
            #1 check($sformatf("v%0d_inready", i), 32'(InReady), 32'(vecs[i].exp_rdy));
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_av", i), 32'(OutAValid), 32'(vecs[i].exp_av));
            check($sformatf("v%0d_ad", i), OutAData, vecs[i].exp_ad);
            check($sformatf("v%0d_bv", i), 32'(OutBValid), 32'(vecs[i].exp_bv));
            check($sformatf("v%0d_bd", i), OutBData, vecs[i].exp_bd);
            check($sformatf("v%0d_ca", i), 32'(CntA), 32'(vecs[i].exp_ca));
            check($sformatf("v%0d_cb", i), 32'(CntB), 32'(vecs[i].exp_cb));
        end

        // Counter wrap on B: 16 handshakes bring CntB back to 0
        @(negedge Clk);
        drive(0, 0, 32'h0, 0, 0, 1);
        @(posedge Clk);
        #1 check("clr_cb", 32'(CntB), 32'h0);
        hs = 0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge Clk);
            drive(0, (i < 16), 32'(i + 100), 0, 1, 0);
            if (i >= 1) hs++;
            @(posedge Clk);
            #1 check($sformatf("wrap_cb%0d", i), 32'(CntB), 32'(hs % 16));
            if (i < 16) check($sformatf("wrap_bd%0d", i), OutBData, 32'(i + 100));
        end
        check("wrap_cb_final", 32'(CntB), 32'h0);
        check("wrap_bv_final", 32'(OutBValid), 32'h0);

        // Clear beats a same-cycle handshake
        @(negedge Clk);
        drive(0, 1, 32'h9, 0, 0, 0);
        @(negedge Clk);
        drive(0, 0, 32'h0, 0, 1, 0);
        @(posedge Clk);
        #1 check("pre_clr_cb", 32'(CntB), 32'h1);
        @(negedge Clk);
        drive(0, 1, 32'hA, 0, 0, 0);
        @(negedge Clk);
        drive(0, 0, 32'h0, 0, 1, 1);
        @(posedge Clk);
        #1;
        check("clr_hs_cb", 32'(CntB), 32'h0);
        check("clr_hs_bv", 32'(OutBValid), 32'h0);

        // Reset mid-stream drops a held payload
        @(negedge Clk);
        drive(1, 1, 32'h10, 0, 0, 0);
        @(negedge Clk);
        drive(1, 1, 32'h11, 1, 0, 0);
        @(posedge Clk);
        #1;
        check("mid_av", 32'(OutAValid), 32'h1);
        check("mid_ad", OutAData, 32'h11);
        check("mid_ca", 32'(CntA), 32'h1);
        drive(1, 0, 32'h0, 0, 0, 0);
        #2 Reset = 1'b0;
        #1;
        check("mid_rst_av", 32'(OutAValid), 32'h0);
        check("mid_rst_ad", OutAData, 32'h0);
        check("mid_rst_ca", 32'(CntA), 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        #1 check("mid_rel_rdy1", 32'(InReady), 32'h1);
        Sel = 1'b0;
        #1 check("mid_rel_rdy0", 32'(InReady), 32'h1);

        // Random traffic against a scoreboard
        m_av = 1'b0; m_bv = 1'b0; n_cons_a = 0; n_cons_b = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            m_rdy = Sel ? (!m_av || OutAReady) : (!m_bv || OutBReady);
            cs_a  = m_av && OutAReady;
            cs_b  = m_bv && OutBReady;
            ld_a  = InValid && m_rdy && Sel;
            ld_b  = InValid && m_rdy && !Sel;
            #1 check("rnd_inready", 32'(InReady), 32'(m_rdy));
            if (cs_a) begin
                n_cons_a++;
                if (qa.size() == 0) check("rnd_a_underflow", 32'h1, 32'h0);
                else check("rnd_ad", OutAData, qa.pop_front());
            end
            if (cs_b) begin
                n_cons_b++;
                if (qb.size() == 0) check("rnd_b_underflow", 32'h1, 32'h0);
                else check("rnd_bd", OutBData, qb.pop_front());
            end
            if (ld_a) qa.push_back(InData);
            if (ld_b) qb.push_back(InData);
            m_av = ld_a || (m_av && !cs_a);
            m_bv = ld_b || (m_bv && !cs_b);
            @(posedge Clk);
            #1;
            check("rnd_av", 32'(OutAValid), 32'(m_av));
            check("rnd_bv", 32'(OutBValid), 32'(m_bv));
        end
        check("rnd_cnta", 32'(CntA), 32'(n_cons_a % 16));
        check("rnd_cntb", 32'(CntB), 32'(n_cons_b % 16));
        check("rnd_qa_left", 32'(qa.size()), 32'(m_av));
        check("rnd_qb_left", 32'(qb.size()), 32'(m_bv));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
